// File: rtl/mul_err_sweep.sv
// ---------------------------------------------------------------------------
// mul_err_sweep
//
// Accuracy characterization engine for a combinational multiplier. It drives
// every operand pair (A outer, B inner) into the multiplier, one per cycle,
// and compares the returned product against the exact A*B. It accumulates:
//   - the number of mismatching pairs
//   - the maximum error distance
//   - the sum of error distances
//   - the operands of the first mismatching pair
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse; starts a sweep from IDLE or DONE
//   busy / done         sweep in progress / statistics valid (level)
//   mul_in1, mul_in2    registered operands presented to the multiplier
//   mul_out,
//   mul_overflow        multiplier result, low bits and MSB
//   err_count           pairs with approx != exact
//   max_ed, sum_ed      max and sum of |approx - exact|
//   first_err_valid,
//   first_err_a/_b      first mismatching pair in sweep order
// ---------------------------------------------------------------------------
module mul_err_sweep #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     mul_in1,
    output logic [WIDTH-1:0]     mul_in2,
    input  logic [2*WIDTH-2:0]   mul_out,
    input  logic                 mul_overflow,
    output logic [2*WIDTH:0]     err_count,
    output logic [2*WIDTH-1:0]   max_ed,
    output logic [4*WIDTH-1:0]   sum_ed,
    output logic                 first_err_valid,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // One combined counter: upper half is A, lower half is B, so a single
    // increment gives "B++, A++ on B wrap" for free.
    logic [PW-1:0]      vec_q, vec_d;
    logic [PW:0]        err_cnt_q, err_cnt_d;
    logic [PW-1:0]      max_ed_q, max_ed_d;
    logic [2*PW-1:0]    sum_ed_q, sum_ed_d;
    logic               fe_vld_q, fe_vld_d;
    logic [WIDTH-1:0]   fe_a_q, fe_a_d;
    logic [WIDTH-1:0]   fe_b_q, fe_b_d;

    logic [WIDTH-1:0]   op_a, op_b;
    logic [PW-1:0]      approx, exact, ed;
    logic               last_vec;
    logic               launch;

    assign op_a     = vec_q[PW-1:WIDTH];
    assign op_b     = vec_q[WIDTH-1:0];
    assign last_vec = &vec_q;
    assign launch   = start && (state_q != S_SWEEP);

    // Error distance for the vector currently on the multiplier inputs.
    assign approx = {mul_overflow, mul_out};
    assign exact  = PW'(op_a) * PW'(op_b);
    assign ed     = (approx >= exact) ? (approx - exact) : (exact - approx);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SWEEP;
            S_SWEEP: if (last_vec) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_SWEEP;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_SWEEP: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        vec_d     = vec_q;
        err_cnt_d = err_cnt_q;
        max_ed_d  = max_ed_q;
        sum_ed_d  = sum_ed_q;
        fe_vld_d  = fe_vld_q;
        fe_a_d    = fe_a_q;
        fe_b_d    = fe_b_q;

        if (launch) begin
            // Fresh sweep: previous statistics are discarded on this edge.
            vec_d     = '0;
            err_cnt_d = '0;
            max_ed_d  = '0;
            sum_ed_d  = '0;
            fe_vld_d  = 1'b0;
            fe_a_d    = '0;
            fe_b_d    = '0;
        end else if (state_q == S_SWEEP) begin
            if (ed != '0) begin
                err_cnt_d = err_cnt_q + 1'b1;
                sum_ed_d  = sum_ed_q + (2*PW)'(ed);
                if (ed > max_ed_q) max_ed_d = ed;
                if (!fe_vld_q) begin
                    fe_vld_d = 1'b1;
                    fe_a_d   = op_a;
                    fe_b_d   = op_b;
                end
            end
            // Counter wraps to zero after the last vector, which also
            // parks the operand outputs at 0 for DONE.
            vec_d = vec_q + 1'b1;
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q     <= '0;
            err_cnt_q <= '0;
            max_ed_q  <= '0;
            sum_ed_q  <= '0;
            fe_vld_q  <= 1'b0;
            fe_a_q    <= '0;
            fe_b_q    <= '0;
        end else begin
            vec_q     <= vec_d;
            err_cnt_q <= err_cnt_d;
            max_ed_q  <= max_ed_d;
            sum_ed_q  <= sum_ed_d;
            fe_vld_q  <= fe_vld_d;
            fe_a_q    <= fe_a_d;
            fe_b_q    <= fe_b_d;
        end
    end

    // The counter is zero outside SWEEP, so operands need no extra gating.
    assign mul_in1         = op_a;
    assign mul_in2         = op_b;
    assign err_count       = err_cnt_q;
    assign max_ed          = max_ed_q;
    assign sum_ed          = sum_ed_q;
    assign first_err_valid = fe_vld_q;
    assign first_err_a     = fe_a_q;
    assign first_err_b     = fe_b_q;

endmodule

// File: tb/tb_mul_err_sweep.sv
// ---------------------------------------------------------------------------
// tb_mul_err_sweep
//
// Bench for mul_err_sweep at WIDTH=4. A behavioural multiplier with several
// error personalities (exact, bit0 stuck low, corner offsets, random offsets)
// is attached to the DUT; expected statistics come from a plain nested loop
// over all operand pairs.
// ---------------------------------------------------------------------------
module tb_mul_err_sweep;

    localparam int W  = 4;
    localparam int NV = 256;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           busy, done;
    logic [W-1:0]   mul_in1, mul_in2;
    logic [2*W-2:0] mul_out;
    logic           mul_overflow;
    logic [2*W:0]   err_count;
    logic [2*W-1:0] max_ed;
    logic [4*W-1:0] sum_ed;
    logic           first_err_valid;
    logic [W-1:0]   first_err_a, first_err_b;

    int n_cmp = 0;
    int n_mis = 0;

    int mode = 0;      // 0 exact, 1 bit0 low, 2 corner offsets, 3 random
    int off [NV];

    always #5 clk = ~clk;

    mul_err_sweep #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mul_in1(mul_in1), .mul_in2(mul_in2),
        .mul_out(mul_out), .mul_overflow(mul_overflow),
        .err_count(err_count), .max_ed(max_ed), .sum_ed(sum_ed),
        .first_err_valid(first_err_valid),
        .first_err_a(first_err_a), .first_err_b(first_err_b)
    );

    // Behavioural multiplier personalities; results clamp to [0,255].
    function automatic int approx_f(input int a, input int b);
        int p;
        p = a * b;
        case (mode)
            1: p = p & ~1;
            2: begin
                if (a == 15 && b == 15) p = p + 5;
                if (a == 0 && b == 0)   p = p - 3;
            end
            3: p = p + off[a*16 + b];
            default: ;
        endcase
        if (p < 0)   p = 0;
        if (p > 255) p = 255;
        return p;
    endfunction

    logic [7:0] prod;
    always_comb prod = 8'(approx_f(int'(mul_in1), int'(mul_in2)));
    assign mul_out      = prod[6:0];
    assign mul_overflow = prod[7];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference statistics over the full operand space, in sweep order.
    task automatic check_stats(input string tag);
        int ec, mx, sm, fa, fb, ed;
        bit fv;
        ec = 0; mx = 0; sm = 0; fv = 0; fa = 0; fb = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                ed = approx_f(a, b) - a * b;
                if (ed < 0) ed = -ed;
                if (ed != 0) begin
                    ec++;
                    sm += ed;
                    if (ed > mx) mx = ed;
                    if (!fv) begin fv = 1; fa = a; fb = b; end
                end
            end
        chk({tag, ".err_count"}, 64'(err_count), 64'(ec));
        chk({tag, ".max_ed"},    64'(max_ed),    64'(mx));
        chk({tag, ".sum_ed"},    64'(sum_ed),    64'(sm));
        chk({tag, ".fe_valid"},  64'(first_err_valid), 64'(fv));
        chk({tag, ".fe_a"},      64'(first_err_a), 64'(fa));
        chk({tag, ".fe_b"},      64'(first_err_b), 64'(fb));
    endtask

    // Drive start for one edge; returns just after the sampling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges after the sampling edge until done. Optionally re-pulse
    // start mid-sweep and spot-check operand outputs.
    task automatic wait_done(input string tag, input bit repulse, output int cyc);
        cyc = 0;
        while (!done && cyc < 400) begin
            if (cyc == 0 || cyc == 37 || cyc == 255) begin
                chk({tag, ".in1"}, 64'(mul_in1), 64'(cyc / 16));
                chk({tag, ".in2"}, 64'(mul_in2), 64'(cyc % 16));
            end
            start = repulse && (cyc == 10 || cyc == 100);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        // 256 SWEEP cycles follow the sampling edge; DONE after edge 256.
        chk({tag, ".latency"}, 64'(cyc), 64'(NV));
        chk({tag, ".busy_done"}, 64'({busy, done}), 64'(2'b01));
        chk({tag, ".ops_zero"}, 64'({mul_in1, mul_in2}), 64'(0));
    endtask

    task automatic run(input string tag, input int m, input bit repulse);
        int cyc;
        mode = m;
        pulse_start();
        chk({tag, ".busy"}, 64'({busy, done}), 64'(2'b10));
        chk({tag, ".cleared"}, 64'({err_count, first_err_valid}), 64'(0));
        wait_done(tag, repulse, cyc);
        check_stats(tag);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < NV; i++)
            off[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) - 20 : 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset.flags", 64'({busy, done}), 64'(0));
        chk("reset.ops", 64'({mul_in1, mul_in2}), 64'(0));
        chk("reset.stats", 64'({err_count, max_ed, sum_ed}), 64'(0));
        chk("reset.fe", 64'({first_err_valid, first_err_a, first_err_b}), 64'(0));

        // Reset wins over a simultaneous start.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_vs_start", 64'({busy, done}), 64'(0));

        run("exact", 0, 1'b0);
        run("bit0", 1, 1'b0);
        // Back-to-back from DONE with errors held: exact model swapped in.
        run("b2b", 0, 1'b0);
        run("corner", 2, 1'b0);
        run("repulse", 3, 1'b1);
        run("random", 3, 1'b0);

        // Reset mid-sweep, then a fresh sweep.
        mode = 1;
        pulse_start();
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst.flags", 64'({busy, done}), 64'(0));
        chk("midrst.ops", 64'({mul_in1, mul_in2}), 64'(0));
        chk("midrst.stats", 64'({err_count, max_ed, sum_ed}), 64'(0));
        chk("midrst.fe", 64'({first_err_valid, first_err_a, first_err_b}), 64'(0));
        // Held in IDLE without start.
        repeat (5) @(posedge clk);
        #1;
        chk("idle_hold", 64'({busy, done}), 64'(0));
        mode = 1;
        pulse_start();
        wait_done("after_rst", 1'b0, cyc);
        check_stats("after_rst");

        // done is a level: it stays high without start.
        repeat (10) @(posedge clk);
        #1;
        chk("done_hold", 64'({busy, done}), 64'(2'b01));
        check_stats("done_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
